corepwm_timebase_gen2: RTL and testbench
========================================

// Module: corepwm_timebase_gen2
// PURPOSE
//  Second-generation PWM timebase: a prescaler followed by a period counter that supports edge-aligned, centre-aligned and one-shot modes.
//  Period, prescale and mode pass through shadow registers that reload only at period boundaries, so reprogramming over APB is glitch-free.
//  Sits between the APB register file and the PWM channel comparators. Feeds them period_cnt, cnt_dir, sync_pulse and period_end.
// PARAMETERS
//  APB_DWIDTH  16  width of period/prescale registers and counters (8..32)
//  SYNC_RESET  0   must be 0 for this block; reset is always asynchronous
// PORTS
//  PCLK          in   1           clock; all logic on rising edge
//  PRESETN       in   1           reset: one clock, asynchronous, active-low; all flops cleared
//  tb_en         in   1           count enable; low freezes all counters
//  period_reg    in   APB_DWIDTH  requested period P
//  prescale_reg  in   APB_DWIDTH  requested prescale S; tick every S+1 PCLKs
//  mode_reg      in   2           00 edge-up, 01 centre up/down, 10 one-shot, 11 treated as 00
//  upd_req       in   1           1-cycle pulse: load shadows at the next boundary
//  sw_restart    in   1           1-cycle pulse: restart the timebase
//  period_cnt    out  APB_DWIDTH  period counter (registered)
//  cnt_dir       out  1           0 = counting up, 1 = counting down (centre mode only)
//  sync_pulse    out  1           registered prescale tick; high on the cycle period_cnt updates
//  period_end    out  1           registered 1-cycle boundary pulse
//  upd_done      out  1           1-cycle pulse: new shadows became active this cycle
//  run           out  1           timebase is counting (one-shot: armed and not yet finished)
// BEHAVIOUR
//  Reset values: all outputs 0; prescale_cnt, shadows (P_a, S_a, M_a), pend and state are all cleared.
//  Shadows:
//   - track the inputs every cycle while tb_en=0 or state=TB_STOP;
//   - otherwise they load only when (pend|upd_req) is set at a boundary tick;
//   - pend is set by upd_req and cleared on load; repeated upd_req while pending has no effect.
//  tick = tb_en & run-state & (prescale_cnt >= S_a).
//   - On tick, prescale_cnt returns to 0; otherwise it increments.
//   - The >= compare absorbs a prescale reduction without a wrap-around.
//  FSM states: TB_STOP, TB_UP, TB_DN.
//   - Exit from reset: TB_UP if M_a != one-shot, else TB_STOP.
//   - Edge mode (TB_UP): on tick, if cnt >= P_a then cnt <= 0 and boundary; else cnt+1.
//   - Centre mode:
//     - TB_UP: on tick with cnt >= P_a, go to TB_DN and set cnt <= (P_a==0) ? 0 : P_a-1.
//     - TB_DN: on tick with cnt == 0, go to TB_UP, set cnt <= (P_a==0) ? 0 : 1, and raise boundary (valley).
//     - TB_DN otherwise: cnt-1.
//     - Period is 2*P_a ticks; with P_a = 0 there is a boundary every tick.
//   - One-shot:
//     - sw_restart moves TB_STOP to TB_UP.
//     - Counts 0..P_a like edge mode; the boundary tick sets cnt <= 0 and goes to TB_STOP.
//     - In TB_STOP, counters hold at 0 and sync_pulse stays low.
//  period_end and sync_pulse register the boundary and tick; they assert in the same cycle as the new period_cnt value.
//  sw_restart has priority over tick and upd logic. Next cycle:
//   - prescale_cnt = 0, period_cnt = 0, cnt_dir = 0, state = TB_UP;
//   - shadows load from the inputs; pend is cleared; upd_done = 1.
//  tb_en low mid-period: counters and dir hold and no pulses occur. On re-assert, counting resumes from the held value.
//  Counter arithmetic is modulo 2^APB_DWIDTH. P = all-ones gives a full-range count with no overflow.
//  Mode change takes effect only via a shadow load.
//   - Changing to centre mode enters TB_UP at cnt 0.
//   - Changing to one-shot enters TB_STOP.
//  run = (state != TB_STOP).
// CONFIGURATION
//  COREPWM_TB_EXT_SYNC_EN defined:
//   - adds input ext_sync (1 bit, asynchronous);
//   - ext_sync passes a 2-flop synchroniser, then a rising-edge detect;
//   - the detected edge acts as sw_restart; counters read 0 three PCLKs after the ext_sync rise.
//  Not defined: the ext_sync port and its logic are absent.
// STRUCTURE
//  Package corepwm_pkg holds:
//   - mode encodings MODE_EDGE/MODE_CENTRE/MODE_ONESHOT;
//   - state encodings TB_STOP/TB_UP/TB_DN.
//  Sub-module corepwm_tb_prescaler: prescale_cnt, the tick compare and restart clear.
//  The top level holds the shadows, the FSM and the output registers.
// TESTING
//  1. Edge mode, P=3, S=1, tb_en=1 -> period_cnt 0,0,1,1,2,2,3,3,0; period_end pulse once every 8 PCLK.
//  2. Centre mode, P=3, S=0 -> 0,1,2,3,2,1,0,1; cnt_dir=1 during 2,1; period_end at each 0 valley (every 6 PCLK).
//  3. Edge mode, P=5: write P=2 with upd_req at cnt=1 -> old P held until cnt 5 -> 0; upd_done then; following periods wrap 2 -> 0.
//  4. One-shot, P=2, S=0: sw_restart -> 0,1,2,0 then hold 0, run=0; second sw_restart repeats the sequence.
//  5. tb_en low at cnt=4 for 10 cycles -> cnt holds 4, no pulses; resumes 5 after re-assert.
//     PRESETN low mid-count -> all outputs 0 asynchronously.
//  6. With COREPWM_TB_EXT_SYNC_EN: ext_sync rises at cnt=7 -> period_cnt=0 three PCLKs later.
//     Without the macro: compile passes and the ext_sync port is absent.

Source files
------------

// File: rtl/corepwm_pkg.sv
// Shared encodings for the second-generation PWM timebase: shadowed mode values and FSM states.
package corepwm_pkg;

    typedef enum logic [1:0] {
        MODE_EDGE    = 2'b00,
        MODE_CENTRE  = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        TB_STOP = 2'b00,
        TB_UP   = 2'b01,
        TB_DN   = 2'b10
    } tb_state_e;

    // The reserved encoding 2'b11 behaves as edge-aligned.
    function automatic mode_e mode_decode(input logic [1:0] raw);
        return (raw == 2'b11) ? MODE_EDGE : mode_e'(raw);
    endfunction

endpackage

// File: rtl/corepwm_tb_prescaler.sv
// Prescaler for the PWM timebase: free-running count that emits a tick every s_i+1 enabled clocks.
module corepwm_tb_prescaler #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [DW-1:0] s_i,
    output logic          tick_o_c
);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // >= rather than == so a lowered prescale takes effect without wrapping the counter.
    always_comb begin
        cnt_d    = cnt_q;
        tick_o_c = 1'b0;
        if (clr_i) begin
            cnt_d = DW'(0);
        end else if (en_i) begin
            if (cnt_q >= s_i) begin
                cnt_d    = DW'(0);
                tick_o_c = 1'b1;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= DW'(0);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/corepwm_timebase_gen2.sv
// PWM timebase (gen2): shadowed period/prescale/mode, edge/centre/one-shot period counter.
// Optional COREPWM_TB_EXT_SYNC_EN adds an asynchronous ext_sync input that acts as sw_restart.
module corepwm_timebase_gen2
    import corepwm_pkg::*;
#(
    parameter int unsigned APB_DWIDTH = 16,
    parameter int unsigned SYNC_RESET = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
`ifdef COREPWM_TB_EXT_SYNC_EN
    input  logic                  ext_sync,
`endif
    input  logic                  tb_en,
    input  logic [APB_DWIDTH-1:0] period_reg,
    input  logic [APB_DWIDTH-1:0] prescale_reg,
    input  logic [1:0]            mode_reg,
    input  logic                  upd_req,
    input  logic                  sw_restart,
    output logic [APB_DWIDTH-1:0] period_cnt,
    output logic                  cnt_dir,
    output logic                  sync_pulse,
    output logic                  period_end,
    output logic                  upd_done,
    output logic                  run
);

    localparam int unsigned W = APB_DWIDTH;

    if (SYNC_RESET != 0) begin : g_sync_reset_check
        $error("corepwm_timebase_gen2: SYNC_RESET must be 0, reset is asynchronous");
    end

    tb_state_e      state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           dir_q, dir_d;
    logic [W-1:0]   p_q, p_d;
    logic [W-1:0]   s_q, s_d;
    mode_e          m_q, m_d;
    logic           pend_q, pend_d;
    logic           sync_q, sync_d;
    logic           pe_q, pe_d;
    logic           upd_q, upd_d;
    logic           run_q, run_d;

    logic           restart_c;
    logic           track_c;
    logic           tick_c;
    logic           presc_en_c;
    logic           presc_clr_c;
    mode_e          mode_in_c;

`ifdef COREPWM_TB_EXT_SYNC_EN
    // Two synchroniser flops plus one delay flop for rising-edge detection.
    logic [2:0] ext_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            ext_q <= 3'b000;
        end else begin
            ext_q <= {ext_q[1:0], ext_sync};
        end
    end

    assign restart_c = sw_restart | (ext_q[1] & ~ext_q[2]);
`else
    assign restart_c = sw_restart;
`endif

    assign mode_in_c   = mode_decode(mode_reg);
    assign track_c     = ~tb_en | (state_q == TB_STOP);
    assign presc_en_c  = tb_en & (state_q != TB_STOP);
    assign presc_clr_c = restart_c | (state_q == TB_STOP);

    corepwm_tb_prescaler #(
        .DW (W)
    ) u_prescaler (
        .clk      (PCLK),
        .rst_n    (PRESETN),
        .en_i     (presc_en_c),
        .clr_i    (presc_clr_c),
        .s_i      (s_q),
        .tick_o_c (tick_c)
    );

    // Priority: restart, then shadow tracking (frozen/stopped), then tick-driven counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        p_d     = p_q;
        s_d     = s_q;
        m_d     = m_q;
        pend_d  = pend_q;
        sync_d  = 1'b0;
        pe_d    = 1'b0;
        upd_d   = 1'b0;

        if (restart_c) begin
            p_d     = period_reg;
            s_d     = prescale_reg;
            m_d     = mode_in_c;
            pend_d  = 1'b0;
            upd_d   = 1'b1;
            state_d = TB_UP;
            cnt_d   = W'(0);
            dir_d   = 1'b0;
        end else if (track_c) begin
            p_d    = period_reg;
            s_d    = prescale_reg;
            m_d    = mode_in_c;
            pend_d = 1'b0;
            if ((state_q == TB_STOP) || (mode_in_c != m_q)) begin
                state_d = (mode_in_c == MODE_ONESHOT) ? TB_STOP : TB_UP;
                cnt_d   = W'(0);
                dir_d   = 1'b0;
            end
        end else begin
            pend_d = pend_q | upd_req;
            if (tick_c) begin
                sync_d = 1'b1;
                case (state_q)
                    TB_UP: begin
                        if (cnt_q >= p_q) begin
                            if ((m_q == MODE_CENTRE) && (p_q != W'(0))) begin
                                state_d = TB_DN;
                                cnt_d   = p_q - W'(1);
                            end else begin
                                cnt_d = W'(0);
                                pe_d  = 1'b1;
                                if (m_q == MODE_ONESHOT) begin
                                    state_d = TB_STOP;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + W'(1);
                        end
                    end
                    TB_DN: begin
                        if (cnt_q == W'(0)) begin
                            state_d = TB_UP;
                            cnt_d   = (p_q == W'(0)) ? W'(0) : W'(1);
                            pe_d    = 1'b1;
                        end else begin
                            cnt_d = cnt_q - W'(1);
                        end
                    end
                    default: ;
                endcase

                // Pending update lands on the boundary; a mode change restarts the new mode at 0.
                if (pe_d && pend_d) begin
                    p_d    = period_reg;
                    s_d    = prescale_reg;
                    m_d    = mode_in_c;
                    pend_d = 1'b0;
                    upd_d  = 1'b1;
                    if (mode_in_c != m_q) begin
                        state_d = (mode_in_c == MODE_ONESHOT) ? TB_STOP : TB_UP;
                        cnt_d   = W'(0);
                    end else if ((m_q == MODE_CENTRE) && (state_q == TB_DN)) begin
                        cnt_d = (period_reg == W'(0)) ? W'(0) : W'(1);
                    end
                end

                // The valley itself is not reported as down-counting.
                dir_d = (state_d == TB_DN) && (cnt_d != W'(0));
            end
        end
    end

    assign run_d = (state_d != TB_STOP);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q <= TB_STOP;
            cnt_q   <= W'(0);
            dir_q   <= 1'b0;
            p_q     <= W'(0);
            s_q     <= W'(0);
            m_q     <= MODE_EDGE;
            pend_q  <= 1'b0;
            sync_q  <= 1'b0;
            pe_q    <= 1'b0;
            upd_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            p_q     <= p_d;
            s_q     <= s_d;
            m_q     <= m_d;
            pend_q  <= pend_d;
            sync_q  <= sync_d;
            pe_q    <= pe_d;
            upd_q   <= upd_d;
            run_q   <= run_d;
        end
    end

    assign period_cnt = cnt_q;
    assign cnt_dir    = dir_q;
    assign sync_pulse = sync_q;
    assign period_end = pe_q;
    assign upd_done   = upd_q;
    assign run        = run_q;

endmodule

// File: tb/tb_corepwm_timebase_gen2.sv
// Self-checking bench for corepwm_timebase_gen2: directed scenarios plus randomized restarts
// compared against a closed-form model of tick count versus mode, period and prescale.
module tb_corepwm_timebase_gen2;

    localparam int unsigned W = 8;

    logic         PCLK;
    logic         PRESETN;
    logic         tb_en;
    logic [W-1:0] period_reg;
    logic [W-1:0] prescale_reg;
    logic [1:0]   mode_reg;
    logic         upd_req;
    logic         sw_restart;
    logic [W-1:0] period_cnt;
    logic         cnt_dir;
    logic         sync_pulse;
    logic         period_end;
    logic         upd_done;
    logic         run;
`ifdef COREPWM_TB_EXT_SYNC_EN
    logic         ext_sync;
`endif

    int checks = 0;
    int errors = 0;

    corepwm_timebase_gen2 #(
        .APB_DWIDTH (W),
        .SYNC_RESET (0)
    ) dut (
        .PCLK         (PCLK),
        .PRESETN      (PRESETN),
`ifdef COREPWM_TB_EXT_SYNC_EN
        .ext_sync     (ext_sync),
`endif
        .tb_en        (tb_en),
        .period_reg   (period_reg),
        .prescale_reg (prescale_reg),
        .mode_reg     (mode_reg),
        .upd_req      (upd_req),
        .sw_restart   (sw_restart),
        .period_cnt   (period_cnt),
        .cnt_dir      (cnt_dir),
        .sync_pulse   (sync_pulse),
        .period_end   (period_end),
        .upd_done     (upd_done),
        .run          (run)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outputs k clocks after a restart, from the tick count t = floor(k/(S+1)).
    function automatic void model(input int m, input int p, input int s, input int k,
                                  output int e_cnt, output int e_dir, output int e_sync,
                                  output int e_pe, output int e_upd, output int e_run);
        int t;
        int pos;
        int sy;
        sy     = ((k > 0) && (k % (s + 1) == 0)) ? 1 : 0;
        t      = k / (s + 1);
        e_upd  = (k == 0) ? 1 : 0;
        e_dir  = 0;
        e_pe   = 0;
        e_run  = 1;
        e_sync = sy;
        case (m)
            1: begin
                if (p == 0) begin
                    e_cnt = 0;
                    e_pe  = sy;
                end else begin
                    pos   = t % (2 * p);
                    e_cnt = (pos <= p) ? pos : (2 * p - pos);
                    e_dir = (pos > p) ? 1 : 0;
                    e_pe  = (sy == 1 && pos == 1 && t > 1) ? 1 : 0;
                end
            end
            2: begin
                e_cnt  = (t <= p) ? t : 0;
                e_run  = (t <= p) ? 1 : 0;
                e_sync = (sy == 1 && t <= p + 1) ? 1 : 0;
                e_pe   = (sy == 1 && t == p + 1) ? 1 : 0;
            end
            default: begin
                e_cnt = t % (p + 1);
                e_pe  = (sy == 1 && e_cnt == 0) ? 1 : 0;
            end
        endcase
    endfunction

    task automatic restart(input int m, input int p, input int s);
        mode_reg     = 2'(m);
        period_reg   = W'(p);
        prescale_reg = W'(s);
        sw_restart   = 1'b1;
        step();
        sw_restart   = 1'b0;
    endtask

    task automatic run_trial(input int m, input int p, input int s, input int n);
        int e_cnt, e_dir, e_sync, e_pe, e_upd, e_run;
        string pfx;
        pfx = $sformatf("m%0d_p%0d_s%0d", m, p, s);
        restart(m, p, s);
        for (int k = 0; k <= n; k++) begin
            if (k > 0) step();
            model(m, p, s, k, e_cnt, e_dir, e_sync, e_pe, e_upd, e_run);
            chk($sformatf("%s_k%0d_cnt", pfx, k), 32'(period_cnt), 32'(e_cnt));
            chk($sformatf("%s_k%0d_dir", pfx, k), 32'(cnt_dir), 32'(e_dir));
            chk($sformatf("%s_k%0d_sync", pfx, k), 32'(sync_pulse), 32'(e_sync));
            chk($sformatf("%s_k%0d_pend", pfx, k), 32'(period_end), 32'(e_pe));
            chk($sformatf("%s_k%0d_upd", pfx, k), 32'(upd_done), 32'(e_upd));
            chk($sformatf("%s_k%0d_run", pfx, k), 32'(run), 32'(e_run));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt"}, 32'(period_cnt), 32'd0);
        chk({tag, "_dir"}, 32'(cnt_dir), 32'd0);
        chk({tag, "_sync"}, 32'(sync_pulse), 32'd0);
        chk({tag, "_pend"}, 32'(period_end), 32'd0);
        chk({tag, "_upd"}, 32'(upd_done), 32'd0);
        chk({tag, "_run"}, 32'(run), 32'd0);
    endtask

    initial begin
        int exp_cnt;
        PRESETN      = 1'b0;
        tb_en        = 1'b1;
        period_reg   = W'(3);
        prescale_reg = W'(0);
        mode_reg     = 2'b00;
        upd_req      = 1'b0;
        sw_restart   = 1'b0;
`ifdef COREPWM_TB_EXT_SYNC_EN
        ext_sync     = 1'b0;
`endif

        // Reset state
        step();
        step();
        chk_all_zero("reset");
        PRESETN = 1'b1;
        step();

        // Edge P=3 S=1, centre P=3 S=0, one-shot twice, P=0 corners, full-range period, mode 11
        run_trial(0, 3, 1, 20);
        run_trial(1, 3, 0, 20);
        run_trial(2, 2, 0, 8);
        run_trial(2, 2, 0, 8);
        run_trial(1, 0, 1, 8);
        run_trial(0, 0, 0, 5);
        run_trial(2, 0, 2, 8);
        run_trial(3, 2, 0, 8);
        run_trial(0, 255, 0, 300);

        // Shadowed period update mid-period: old P=5 completes, then P=2
        restart(0, 5, 0);
        step();
        chk("upd_k1_cnt", 32'(period_cnt), 32'd1);
        period_reg = W'(2);
        upd_req    = 1'b1;
        step();
        upd_req    = 1'b0;
        for (int k = 2; k <= 14; k++) begin
            if (k > 2) step();
            exp_cnt = (k < 6) ? k : (k - 6) % 3;
            chk($sformatf("upd_k%0d_cnt", k), 32'(period_cnt), 32'(exp_cnt));
            chk($sformatf("upd_k%0d_done", k), 32'(upd_done), (k == 6) ? 32'd1 : 32'd0);
            chk($sformatf("upd_k%0d_pend", k), 32'(period_end), (exp_cnt == 0) ? 32'd1 : 32'd0);
        end

        // Freeze with tb_en low at cnt=4, then resume at 5
        restart(0, 9, 0);
        for (int k = 1; k <= 4; k++) step();
        chk("frz_pre_cnt", 32'(period_cnt), 32'd4);
        tb_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("frz_%0d_cnt", k), 32'(period_cnt), 32'd4);
            chk($sformatf("frz_%0d_sync", k), 32'(sync_pulse), 32'd0);
            chk($sformatf("frz_%0d_pend", k), 32'(period_end), 32'd0);
        end
        tb_en = 1'b1;
        step();
        chk("frz_resume_cnt", 32'(period_cnt), 32'd5);
        chk("frz_resume_sync", 32'(sync_pulse), 32'd1);

        // Asynchronous reset mid-count
        step();
        #2;
        PRESETN = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        step();
        PRESETN = 1'b1;
        step();

`ifdef COREPWM_TB_EXT_SYNC_EN
        // ext_sync rising at cnt=7 restarts the count three clocks later
        restart(0, 20, 0);
        for (int k = 1; k <= 7; k++) step();
        chk("ext_pre_cnt", 32'(period_cnt), 32'd7);
        ext_sync = 1'b1;
        step();
        step();
        chk("ext_2clk_cnt", 32'(period_cnt), 32'd9);
        step();
        chk("ext_3clk_cnt", 32'(period_cnt), 32'd0);
        chk("ext_3clk_upd", 32'(upd_done), 32'd1);
        ext_sync = 1'b0;
        step();
`endif

        // Randomized restarts against the model
        for (int i = 0; i < 12; i++) begin
            run_trial(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 3)), 40);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
